// File: rtl/m1_alu_sched_pkg.sv
// rtl/m1_alu_sched_pkg.sv - shared types, widths and opcodes for the M1 ALU issue scheduler
package m1_alu_sched_pkg;

   localparam int SCHED_DATA_W = 16;
   localparam int SCHED_ADDR_W = 4;

   localparam logic [3:0] ADD = 4'h0;
   localparam logic [3:0] SUB = 4'h1;
   localparam logic [3:0] AND = 4'h2;
   localparam logic [3:0] OR  = 4'h3;
   localparam logic [3:0] XOR = 4'h4;
   localparam logic [3:0] SLL = 4'h5;
   localparam logic [3:0] SRL = 4'h6;
   localparam logic [3:0] EQ  = 4'h7;
   localparam logic [3:0] NE  = 4'h8;
   localparam logic [3:0] LT  = 4'h9;
   localparam logic [3:0] LTU = 4'hA;
   localparam logic [3:0] SRA = 4'hB;
   localparam logic [3:0] NOT = 4'hC;
   localparam logic [3:0] NEG = 4'hD;
   localparam logic [3:0] NOR = 4'hE;
   localparam logic [3:0] MOV = 4'hF;

   typedef struct packed {
      logic [3:0]              op;
      logic                    type_sel;
      logic [SCHED_ADDR_W-1:0] dest;
      logic [SCHED_DATA_W-1:0] data1;
      logic [SCHED_DATA_W-1:0] data2;
   } alu_req_t;

   typedef struct packed {
      logic [SCHED_DATA_W-1:0] data;
      logic [SCHED_ADDR_W-1:0] dest;
      logic                    src;
   } alu_wb_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way arbiter; M1_ALU_SCHED_RR_EN selects round-robin, else lane 0 fixed priority
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant
);

`ifdef M1_ALU_SCHED_RR_EN
   logic r_last_grant;

   // Reset to lane 1 so that the first contention goes to lane 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_last_grant <= 1'b1;
      end else if (advance) begin
         r_last_grant <= grant[1];
      end
   end

   always_comb begin
      grant = req;
      if (&req) begin
         grant = r_last_grant ? 2'b01 : 2'b10;
      end
   end
`else
   logic w_unused;

   assign w_unused = &{1'b0, clk, rst, advance};

   always_comb begin
      grant = req;
      if (req[0]) begin
         grant = 2'b01;
      end
   end
`endif

endmodule

// File: rtl/alu_issue_scheduler.sv
// rtl/alu_issue_scheduler.sv - two-lane ALU issue scheduler with IS/WB stages; policy via M1_ALU_SCHED_RR_EN
module alu_issue_scheduler
   import m1_alu_sched_pkg::*;
#(
   parameter int DATA_W = SCHED_DATA_W,
   parameter int ADDR_W = SCHED_ADDR_W
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic [1:0]             req_valid,
   output logic [1:0]             req_ready,
   input  logic [1:0][3:0]        req_op,
   input  logic [1:0]             req_type,
   input  logic [1:0][ADDR_W-1:0] req_dest,
   input  logic [1:0][DATA_W-1:0] req_data1,
   input  logic [1:0][DATA_W-1:0] req_data2,
   output logic                   alu_call,
   output logic [3:0]             alu_operation,
   output logic                   alu_type_select,
   output logic [ADDR_W-1:0]      alu_dest_addr,
   output logic [DATA_W-1:0]      alu_data_in1,
   output logic [DATA_W-1:0]      alu_data_in2,
   input  logic [DATA_W-1:0]      alu_data_out,
   input  logic [ADDR_W-1:0]      alu_dest_addr_out,
   input  logic                   alu_valid_out,
   output logic                   wb_valid,
   input  logic                   wb_ready,
   output logic [DATA_W-1:0]      wb_data,
   output logic [ADDR_W-1:0]      wb_dest,
   output logic                   wb_src,
   output logic                   busy
);

   logic       r_is_valid;
   logic       r_is_src;
   alu_req_t   r_is;
   logic       r_wb_valid;
   alu_wb_t    r_wb;

   logic       w_wb_adv;
   logic       w_is_adv;
   logic       w_arb_en;
   logic       w_accept;
   logic       w_wb_load;
   logic [1:0] w_arb_req;
   logic [1:0] w_grant;
   alu_req_t   w_lane [2];
   alu_req_t   w_sel;

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         w_lane[i] = '{op: req_op[i], type_sel: req_type[i], dest: req_dest[i],
                       data1: req_data1[i], data2: req_data2[i]};
      end
   end

   assign w_wb_adv  = ~r_wb_valid | wb_ready;
   assign w_is_adv  = ~r_is_valid | w_wb_adv;
   // Masking requests keeps req_ready low during reset, flush and stalls.
   assign w_arb_en  = w_is_adv & ~flush & ~rst;
   assign w_arb_req = req_valid & {2{w_arb_en}};
   assign w_accept  = |w_grant;
   assign w_sel     = w_grant[1] ? w_lane[1] : w_lane[0];
   assign w_wb_load = r_is_valid & alu_valid_out;

   rr_arb2 u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (w_arb_req),
      .advance (w_accept),
      .grant   (w_grant)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_is_valid <= 1'b0;
         r_is_src   <= 1'b0;
         r_is       <= '0;
         r_wb_valid <= 1'b0;
         r_wb       <= '0;
      end else if (flush) begin
         r_is_valid <= 1'b0;
         r_wb_valid <= 1'b0;
      end else begin
         if (w_is_adv) begin
            r_is_valid <= w_accept;
            if (w_accept) begin
               r_is     <= w_sel;
               r_is_src <= w_grant[1];
            end
         end
         if (w_wb_adv) begin
            r_wb_valid <= w_wb_load;
            if (w_wb_load) begin
               r_wb <= '{data: alu_data_out, dest: alu_dest_addr_out, src: r_is_src};
            end
         end
      end
   end

   assign req_ready       = w_grant;
   assign alu_call        = r_is_valid;
   assign alu_operation   = r_is.op;
   assign alu_type_select = r_is.type_sel;
   assign alu_dest_addr   = r_is.dest;
   assign alu_data_in1    = r_is.data1;
   assign alu_data_in2    = r_is.data2;
   assign wb_valid        = r_wb_valid;
   assign wb_data         = r_wb.data;
   assign wb_dest         = r_wb.dest;
   assign wb_src          = r_wb.src;
   assign busy            = r_is_valid | r_wb_valid;

endmodule
